// File: rtl/airi5c_fdiv_sched.sv
// Round-robin scheduler sharing one iterative FP div/sqrt unit between two requesters.
// Special operands are answered directly; everything else is sequenced through the unit.
module airi5c_fdiv_sched #(
    parameter int unsigned UNIT_TIMEOUT = 64
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       kill,
    input  logic [1:0] req_valid,
    input  logic [1:0] req_op,
    input  logic [9:0] req_a_cls,
    input  logic [9:0] req_b_cls,
    output logic [1:0] req_ready,
    output logic       unit_start,
    output logic       unit_op,
    output logic       unit_owner,
    output logic       unit_kill,
    input  logic       unit_done,
    output logic [1:0] resp_valid,
    output logic       resp_special,
    output logic [1:0] resp_code,
    output logic       resp_nv,
    output logic       resp_dz,
    output logic       busy,
    output logic       timeout_err
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SPECIAL,
        S_START,
        S_WAIT,
        S_RESP
    } state_t;

    state_t     state_q, state_d;
    logic       rr_last_q, rr_last_d;
    logic       owner_q, owner_d;
    logic       op_q, op_d;
    logic [1:0] code_q, code_d;
    logic       nv_q, nv_d;
    logic       dz_q, dz_d;
    logic       tmo_q, tmo_d;
    logic [7:0] timer_q, timer_d;
    logic       timeout_err_q, timeout_err_d;

    logic       gnt_idx;
    logic       sel_op;
    logic [4:0] sel_a, sel_b;
    logic       a_nan, b_nan;
    logic       cls_special;
    logic [1:0] cls_code;
    logic       cls_nv, cls_dz;
    logic       unused_b_sgn;

    // With both requesting, the one not served last wins.
    assign gnt_idx      = (req_valid == 2'b11) ? ~rr_last_q : req_valid[1];
    assign sel_op       = gnt_idx ? req_op[1] : req_op[0];
    assign sel_a        = gnt_idx ? req_a_cls[9:5] : req_a_cls[4:0];
    assign sel_b        = gnt_idx ? req_b_cls[9:5] : req_b_cls[4:0];
    assign unused_b_sgn = sel_b[4];
    assign a_nan        = sel_a[3] | sel_a[2];
    assign b_nan        = sel_b[3] | sel_b[2];

    // Class bits: [4]=sgn [3]=sNaN [2]=qNaN [1]=inf [0]=zero
    always_comb begin
        cls_special = 1'b1;
        cls_code    = 2'b00;
        cls_nv      = 1'b0;
        cls_dz      = 1'b0;
        if (!sel_op) begin
            if (a_nan || b_nan) begin
                cls_code = 2'b01;
                cls_nv   = sel_a[3] | sel_b[3];
            end else if ((sel_a[1] && sel_b[1]) || (sel_a[0] && sel_b[0])) begin
                cls_code = 2'b01;
                cls_nv   = 1'b1;
            end else if (sel_a[1]) begin
                cls_code = 2'b10;
            end else if (sel_b[0]) begin
                cls_code = 2'b10;
                cls_dz   = 1'b1;
            end else if (sel_a[0] || sel_b[1]) begin
                cls_code = 2'b11;
            end else begin
                cls_special = 1'b0;
            end
        end else begin
            if (a_nan) begin
                cls_code = 2'b01;
                cls_nv   = sel_a[3];
            end else if (sel_a[0]) begin
                cls_code = 2'b11;
            end else if (sel_a[4]) begin
                cls_code = 2'b01;
                cls_nv   = 1'b1;
            end else if (sel_a[1]) begin
                cls_code = 2'b10;
            end else begin
                cls_special = 1'b0;
            end
        end
    end

    always_comb begin
        state_d       = state_q;
        rr_last_d     = rr_last_q;
        owner_d       = owner_q;
        op_d          = op_q;
        code_d        = code_q;
        nv_d          = nv_q;
        dz_d          = dz_q;
        tmo_d         = tmo_q;
        timer_d       = timer_q;
        timeout_err_d = timeout_err_q;
        req_ready     = '0;
        unit_start    = 1'b0;
        unit_kill     = 1'b0;
        resp_valid    = '0;
        resp_special  = 1'b0;
        resp_code     = 2'b00;
        resp_nv       = 1'b0;
        resp_dz       = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (|req_valid) begin
                    req_ready[gnt_idx] = 1'b1;
                    owner_d            = gnt_idx;
                    op_d               = sel_op;
                    rr_last_d          = gnt_idx;
                    code_d             = cls_code;
                    nv_d               = cls_nv;
                    dz_d               = cls_dz;
                    tmo_d              = 1'b0;
                    state_d            = cls_special ? S_SPECIAL : S_START;
                end
            end
            S_SPECIAL: begin
                resp_valid[owner_q] = 1'b1;
                resp_special        = 1'b1;
                resp_code           = code_q;
                resp_nv             = nv_q;
                resp_dz             = dz_q;
                state_d             = S_IDLE;
            end
            S_START: begin
                unit_start = 1'b1;
                timer_d    = '0;
                state_d    = S_WAIT;
            end
            S_WAIT: begin
                timer_d = timer_q + 8'd1;
                if (unit_done) begin
                    state_d = S_RESP;
                end else if (timer_q == 8'(UNIT_TIMEOUT - 1)) begin
                    unit_kill     = 1'b1;
                    timeout_err_d = 1'b1;
                    tmo_d         = 1'b1;
                    state_d       = S_RESP;
                end
            end
            S_RESP: begin
                resp_valid[owner_q] = 1'b1;
                resp_code           = tmo_q ? 2'b01 : 2'b00;
                resp_nv             = tmo_q;
                state_d             = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        // A flush discards everything decided above except the abort to the unit.
        if (kill) begin
            state_d       = S_IDLE;
            rr_last_d     = rr_last_q;
            owner_d       = owner_q;
            op_d          = op_q;
            code_d        = code_q;
            nv_d          = nv_q;
            dz_d          = dz_q;
            tmo_d         = tmo_q;
            timeout_err_d = timeout_err_q;
            req_ready     = '0;
            unit_start    = 1'b0;
            resp_valid    = '0;
            resp_special  = 1'b0;
            resp_code     = 2'b00;
            resp_nv       = 1'b0;
            resp_dz       = 1'b0;
            unit_kill     = (state_q == S_START) || (state_q == S_WAIT);
        end

        if (reset) begin
            req_ready    = '0;
            unit_start   = 1'b0;
            unit_kill    = 1'b0;
            resp_valid   = '0;
            resp_special = 1'b0;
            resp_code    = 2'b00;
            resp_nv      = 1'b0;
            resp_dz      = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= S_IDLE;
            rr_last_q     <= 1'b1;
            owner_q       <= 1'b0;
            op_q          <= 1'b0;
            code_q        <= 2'b00;
            nv_q          <= 1'b0;
            dz_q          <= 1'b0;
            tmo_q         <= 1'b0;
            timer_q       <= '0;
            timeout_err_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            rr_last_q     <= rr_last_d;
            owner_q       <= owner_d;
            op_q          <= op_d;
            code_q        <= code_d;
            nv_q          <= nv_d;
            dz_q          <= dz_d;
            tmo_q         <= tmo_d;
            timer_q       <= timer_d;
            timeout_err_q <= timeout_err_d;
        end
    end

    assign unit_op     = op_q;
    assign unit_owner  = owner_q;
    assign busy        = (state_q != S_IDLE);
    assign timeout_err = timeout_err_q;

endmodule

// File: tb/tb_airi5c_fdiv_sched.sv
// Directed and randomized checks of the div/sqrt scheduler against a cycle-timeline model.
module tb_airi5c_fdiv_sched;

    localparam int RN = 400;
    localparam logic [4:0] C_NORM = 5'b00000;
    localparam logic [4:0] C_NEG  = 5'b10000;
    localparam logic [4:0] C_ZERO = 5'b00001;
    localparam logic [4:0] C_INF  = 5'b00010;
    localparam logic [4:0] C_SNAN = 5'b01000;

    logic       clk = 1'b0;
    logic       reset, kill, unit_done;
    logic [1:0] req_valid, req_op;
    logic [9:0] req_a_cls, req_b_cls;

    logic [1:0] req_ready, resp_valid, resp_code;
    logic       unit_start, unit_op, unit_owner, unit_kill;
    logic       resp_special, resp_nv, resp_dz, busy, timeout_err;

    logic [1:0] req_ready_t, resp_valid_t, resp_code_t;
    logic       unit_start_t, unit_op_t, unit_owner_t, unit_kill_t;
    logic       resp_special_t, resp_nv_t, resp_dz_t, busy_t, timeout_err_t;

    int checks = 0;
    int failures = 0;

    airi5c_fdiv_sched dut (
        .clk(clk), .reset(reset), .kill(kill),
        .req_valid(req_valid), .req_op(req_op),
        .req_a_cls(req_a_cls), .req_b_cls(req_b_cls),
        .req_ready(req_ready), .unit_start(unit_start), .unit_op(unit_op),
        .unit_owner(unit_owner), .unit_kill(unit_kill), .unit_done(unit_done),
        .resp_valid(resp_valid), .resp_special(resp_special), .resp_code(resp_code),
        .resp_nv(resp_nv), .resp_dz(resp_dz), .busy(busy), .timeout_err(timeout_err)
    );

    airi5c_fdiv_sched #(.UNIT_TIMEOUT(8)) dut_t (
        .clk(clk), .reset(reset), .kill(kill),
        .req_valid(req_valid), .req_op(req_op),
        .req_a_cls(req_a_cls), .req_b_cls(req_b_cls),
        .req_ready(req_ready_t), .unit_start(unit_start_t), .unit_op(unit_op_t),
        .unit_owner(unit_owner_t), .unit_kill(unit_kill_t), .unit_done(unit_done),
        .resp_valid(resp_valid_t), .resp_special(resp_special_t), .resp_code(resp_code_t),
        .resp_nv(resp_nv_t), .resp_dz(resp_dz_t), .busy(busy_t), .timeout_err(timeout_err_t)
    );

    always #5 clk = ~clk;

    // Expected per-cycle timeline for the randomized phase
    logic [1:0] e_ready [RN+32];
    logic [1:0] e_resp  [RN+32];
    logic [1:0] e_code  [RN+32];
    logic       e_start [RN+32];
    logic       e_done  [RN+32];
    logic       e_wait  [RN+32];
    logic       e_spec  [RN+32];
    logic       e_nv    [RN+32];
    logic       e_dz    [RN+32];
    logic       e_busy  [RN+32];
    logic       e_owner [RN+32];

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Enter the next clock cycle; inputs are driven here, outputs sampled after #1.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        kill      = 1'b0;
        unit_done = 1'b0;
        req_valid = '0;
        req_op    = '0;
        req_a_cls = '0;
        req_b_cls = '0;
    endtask

    task automatic set_req(input int i, input logic op, input logic [4:0] a, input logic [4:0] b);
        req_valid[i]         = 1'b1;
        req_op[i]            = op;
        req_a_cls[i*5 +: 5]  = a;
        req_b_cls[i*5 +: 5]  = b;
    endtask

    task automatic do_reset();
        cyc();
        clear_inputs();
        reset = 1'b1;
        cyc();
        cyc();
        reset = 1'b0;
    endtask

    function automatic logic [1:0] onehot(input int i);
        return (i == 0) ? 2'b01 : 2'b10;
    endfunction

    // {special, code[1:0], nv, dz} from the IEEE special-operand rules
    function automatic logic [4:0] ref_class(input logic op, input logic [4:0] a, input logic [4:0] b);
        logic an, bn;
        an = a[3] | a[2];
        bn = b[3] | b[2];
        if (op == 1'b0) begin
            if (an || bn)                           return {1'b1, 2'b01, a[3] | b[3], 1'b0};
            if ((a[1] && b[1]) || (a[0] && b[0]))   return {1'b1, 2'b01, 1'b1, 1'b0};
            if (a[1])                               return {1'b1, 2'b10, 1'b0, 1'b0};
            if (b[0])                               return {1'b1, 2'b10, 1'b0, 1'b1};
            if (a[0] || b[1])                       return {1'b1, 2'b11, 1'b0, 1'b0};
            return 5'b0;
        end
        if (an)   return {1'b1, 2'b01, a[3], 1'b0};
        if (a[0]) return {1'b1, 2'b11, 1'b0, 1'b0};
        if (a[4]) return {1'b1, 2'b01, 1'b1, 1'b0};
        if (a[1]) return {1'b1, 2'b10, 1'b0, 1'b0};
        return 5'b0;
    endfunction

    function automatic logic [4:0] rnd_cls();
        logic s;
        s = 1'($urandom_range(0, 1));
        case ($urandom_range(0, 7))
            4:       return {s, 4'b0001};
            5:       return {s, 4'b0010};
            6:       return {s, 4'b0100};
            7:       return {s, 4'b1000};
            default: return {s, 4'b0000};
        endcase
    endfunction

    task automatic special_case(input string tag, input int i, input logic op,
                                input logic [4:0] a, input logic [4:0] b,
                                input logic [1:0] code, input logic nv, input logic dz);
        cyc();
        clear_inputs();
        set_req(i, op, a, b);
        #1;
        chk({tag, "_ready"}, req_ready, onehot(i));
        chk({tag, "_nostart0"}, unit_start, 1'b0);
        cyc();
        clear_inputs();
        #1;
        chk({tag, "_resp"}, resp_valid, onehot(i));
        chk({tag, "_special"}, resp_special, 1'b1);
        chk({tag, "_code"}, resp_code, code);
        chk({tag, "_nv"}, resp_nv, nv);
        chk({tag, "_dz"}, resp_dz, dz);
        chk({tag, "_nostart1"}, unit_start, 1'b0);
        cyc();
        #1;
        chk({tag, "_idle"}, busy, 1'b0);
        chk({tag, "_resp_off"}, resp_valid, 2'b00);
    endtask

    task automatic drain();
        int n;
        clear_inputs();
        n = 0;
        while ((busy || busy_t) && n < 40) begin
            cyc();
            n++;
        end
        cyc();
        #1;
        chk("drain_idle", busy, 1'b0);
    endtask

    initial begin
        int last_acc, grants, g, lat, s, nxt_free;
        logic m_rr;
        logic       pend [2];
        logic       p_op [2];
        logic [4:0] p_a  [2];
        logic [4:0] p_b  [2];
        logic [4:0] r;

        clear_inputs();
        reset = 1'b1;

        // Reset state, and reset overriding a pending request
        cyc();
        req_valid = 2'b11;
        #1;
        chk("rst_ready_blocked", req_ready, 2'b00);
        do_reset();
        #1;
        chk("rst_ready", req_ready, 2'b00);
        chk("rst_start", unit_start, 1'b0);
        chk("rst_kill", unit_kill, 1'b0);
        chk("rst_resp", resp_valid, 2'b00);
        chk("rst_busy", busy, 1'b0);
        chk("rst_owner", unit_owner, 1'b0);
        chk("rst_op", unit_op, 1'b0);
        chk("rst_tmo", timeout_err, 1'b0);
        chk("rst_tmo_t", timeout_err_t, 1'b0);

        // req0 div 6.0/2.0 through the unit, done 10 cycles after start
        cyc();
        set_req(0, 1'b0, C_NORM, C_NORM);
        #1;
        chk("div_ready", req_ready, 2'b01);
        cyc();
        clear_inputs();
        #1;
        chk("div_start", unit_start, 1'b1);
        chk("div_busy", busy, 1'b1);
        chk("div_owner", unit_owner, 1'b0);
        chk("div_op", unit_op, 1'b0);
        for (int k = 1; k <= 10; k++) begin
            cyc();
            unit_done = (k == 10);
            #1;
            chk("div_wait_noresp", resp_valid, 2'b00);
            chk("div_wait_nostart", unit_start, 1'b0);
        end
        cyc();
        unit_done = 1'b0;
        #1;
        chk("div_resp", resp_valid, 2'b01);
        chk("div_resp_special", resp_special, 1'b0);
        chk("div_resp_code", resp_code, 2'b00);
        chk("div_resp_nv", resp_nv, 1'b0);
        drain();

        // Both requesters valid continuously: grants alternate 0,1,0,1,0 every 4 cycles
        do_reset();
        grants   = 0;
        last_acc = 0;
        for (int c = 0; c < 20; c++) begin
            cyc();
            req_valid = 2'b11;
            unit_done = 1'b1;
            #1;
            if (req_ready != 2'b00) begin
                chk("rr_grant", req_ready, onehot(grants % 2));
                if (grants > 0) chk("rr_spacing", 8'(c - last_acc), 8'd4);
                last_acc = c;
                grants++;
            end
        end
        chk("rr_count", 8'(grants), 8'd5);
        drain();

        // Special operands resolved without the unit
        special_case("div_x_by_0", 1, 1'b0, C_NORM, C_ZERO, 2'b10, 1'b0, 1'b1);
        special_case("sqrt_neg", 0, 1'b1, C_NEG, C_NORM, 2'b01, 1'b1, 1'b0);
        special_case("div_0_by_0", 0, 1'b0, C_ZERO, C_ZERO, 2'b01, 1'b1, 1'b0);
        special_case("div_snan", 0, 1'b0, C_SNAN, C_NORM, 2'b01, 1'b1, 1'b0);
        special_case("sqrt_pinf", 1, 1'b1, C_INF, C_NORM, 2'b10, 1'b0, 1'b0);

        // Timeout on the UNIT_TIMEOUT=8 instance
        do_reset();
        cyc();
        set_req(0, 1'b0, C_NORM, C_NORM);
        #1;
        chk("tmo_ready", req_ready_t, 2'b01);
        cyc();
        clear_inputs();
        #1;
        chk("tmo_start", unit_start_t, 1'b1);
        for (int k = 1; k <= 8; k++) begin
            cyc();
            #1;
            chk("tmo_kill", unit_kill_t, (k == 8) ? 1'b1 : 1'b0);
        end
        cyc();
        #1;
        chk("tmo_resp", resp_valid_t, 2'b01);
        chk("tmo_code", resp_code_t, 2'b01);
        chk("tmo_nv", resp_nv_t, 1'b1);
        chk("tmo_special", resp_special_t, 1'b0);
        chk("tmo_err", timeout_err_t, 1'b1);
        repeat (5) cyc();
        #1;
        chk("tmo_err_sticky", timeout_err_t, 1'b1);
        chk("tmo_idle", busy_t, 1'b0);
        do_reset();
        #1;
        chk("tmo_err_cleared", timeout_err_t, 1'b0);

        // Done on the timeout cycle wins
        cyc();
        set_req(0, 1'b0, C_NORM, C_NORM);
        cyc();
        clear_inputs();
        for (int k = 1; k <= 8; k++) begin
            cyc();
            unit_done = (k == 8);
            #1;
            chk("edge_nokill", unit_kill_t, 1'b0);
        end
        cyc();
        unit_done = 1'b0;
        #1;
        chk("edge_resp", resp_valid_t, 2'b01);
        chk("edge_code", resp_code_t, 2'b00);
        chk("edge_nv", resp_nv_t, 1'b0);
        cyc();
        #1;
        chk("edge_no_err", timeout_err_t, 1'b0);
        drain();

        // Kill 3 cycles into WAIT; a later done is ignored
        cyc();
        set_req(0, 1'b0, C_NORM, C_NORM);
        cyc();
        clear_inputs();
        cyc();
        cyc();
        cyc();
        kill = 1'b1;
        #1;
        chk("killw_unit_kill", unit_kill, 1'b1);
        chk("killw_noresp", resp_valid, 2'b00);
        cyc();
        kill = 1'b0;
        #1;
        chk("killw_idle", busy, 1'b0);
        chk("killw_kill_off", unit_kill, 1'b0);
        cyc();
        unit_done = 1'b1;
        #1;
        chk("killw_late_done", resp_valid, 2'b00);
        cyc();
        unit_done = 1'b0;
        #1;
        chk("killw_late_done2", resp_valid, 2'b00);
        chk("killw_still_idle", busy, 1'b0);

        // Kill in START suppresses the start pulse
        cyc();
        set_req(1, 1'b1, C_NORM, C_NORM);
        cyc();
        clear_inputs();
        kill = 1'b1;
        #1;
        chk("kills_nostart", unit_start, 1'b0);
        chk("kills_unit_kill", unit_kill, 1'b1);
        cyc();
        kill = 1'b0;
        #1;
        chk("kills_idle", busy, 1'b0);

        // Kill in SPECIAL suppresses the response, no unit_kill
        cyc();
        set_req(1, 1'b1, C_INF, C_NORM);
        cyc();
        clear_inputs();
        kill = 1'b1;
        #1;
        chk("killsp_noresp", resp_valid, 2'b00);
        chk("killsp_no_unit_kill", unit_kill, 1'b0);
        cyc();
        kill = 1'b0;
        #1;
        chk("killsp_idle", busy, 1'b0);

        // Kill in IDLE blocks the grant for that cycle only
        cyc();
        set_req(0, 1'b0, C_NORM, C_NORM);
        kill = 1'b1;
        #1;
        chk("killi_blocked", req_ready, 2'b00);
        cyc();
        kill = 1'b0;
        #1;
        chk("killi_ready", req_ready, 2'b01);
        cyc();
        clear_inputs();
        #1;
        chk("killi_start", unit_start, 1'b1);
        cyc();
        unit_done = 1'b1;
        cyc();
        unit_done = 1'b0;
        #1;
        chk("killi_resp", resp_valid, 2'b01);
        drain();

        // Randomized traffic against a timeline model
        do_reset();
        for (int c = 0; c < RN + 32; c++) begin
            e_ready[c] = '0; e_resp[c] = '0; e_code[c] = '0; e_start[c] = 1'b0;
            e_done[c] = 1'b0; e_wait[c] = 1'b0; e_spec[c] = 1'b0; e_nv[c] = 1'b0;
            e_dz[c] = 1'b0; e_busy[c] = 1'b0; e_owner[c] = 1'b0;
        end
        m_rr     = 1'b1;
        nxt_free = 0;
        for (int i = 0; i < 2; i++) begin
            pend[i] = 1'b0; p_op[i] = 1'b0; p_a[i] = '0; p_b[i] = '0;
        end
        for (int c = 0; c < RN; c++) begin
            cyc();
            for (int i = 0; i < 2; i++) begin
                if (!pend[i] && c < RN - 60 && $urandom_range(0, 2) == 0) begin
                    pend[i] = 1'b1;
                    p_op[i] = 1'($urandom_range(0, 1));
                    p_a[i]  = rnd_cls();
                    p_b[i]  = rnd_cls();
                end
            end
            g = -1;
            if (c >= nxt_free && (pend[0] || pend[1])) begin
                if (pend[0] && pend[1]) g = m_rr ? 0 : 1;
                else                    g = pend[1] ? 1 : 0;
                m_rr       = 1'(g);
                e_ready[c] = onehot(g);
                r = ref_class(p_op[g], p_a[g], p_b[g]);
                if (r[4]) begin
                    e_resp[c+1]  = onehot(g);
                    e_spec[c+1]  = 1'b1;
                    e_code[c+1]  = r[3:2];
                    e_nv[c+1]    = r[1];
                    e_dz[c+1]    = r[0];
                    e_busy[c+1]  = 1'b1;
                    e_owner[c+1] = 1'(g);
                    nxt_free     = c + 2;
                end else begin
                    lat = $urandom_range(1, 12);
                    s   = c + 1;
                    e_start[s] = 1'b1;
                    for (int k = 1; k <= lat; k++) e_wait[s+k] = 1'b1;
                    e_done[s+lat]  = 1'b1;
                    e_resp[s+lat+1] = onehot(g);
                    for (int k = s; k <= s + lat + 1; k++) begin
                        e_busy[k]  = 1'b1;
                        e_owner[k] = 1'(g);
                    end
                    nxt_free = s + lat + 2;
                end
            end
            req_valid = {pend[1], pend[0]};
            req_op    = {p_op[1], p_op[0]};
            req_a_cls = {p_a[1], p_a[0]};
            req_b_cls = {p_b[1], p_b[0]};
            unit_done = e_done[c] || (!e_wait[c] && $urandom_range(0, 3) == 0);
            #1;
            chk("rnd_ready", req_ready, e_ready[c]);
            chk("rnd_start", unit_start, e_start[c]);
            chk("rnd_resp", resp_valid, e_resp[c]);
            chk("rnd_busy", busy, e_busy[c]);
            chk("rnd_unit_kill", unit_kill, 1'b0);
            if (e_busy[c]) chk("rnd_owner", unit_owner, e_owner[c]);
            if (e_resp[c] != 2'b00) begin
                chk("rnd_special", resp_special, e_spec[c]);
                chk("rnd_code", resp_code, e_code[c]);
                chk("rnd_nv", resp_nv, e_nv[c]);
                chk("rnd_dz", resp_dz, e_dz[c]);
            end
            if (g >= 0) pend[g] = 1'b0;
        end
        clear_inputs();
        chk("rnd_no_tmo", timeout_err, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
